dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-back, write-allocate L1 data cache controller sitting between the MEM stage and off-chip data memory. It is the source of `mem_stall_o`, which drives the pipeline registers' `MemStall_i` inputs and freezes the pipeline for the full duration of a miss. Tag, valid, dirty and data arrays are internal register arrays. The memory side moves whole 256-bit (32-byte) blocks over a level-request / single-cycle-ack handshake.

## Interface
- `NUM_LINES`, default 32: cache lines; power of 2. `IDX_W = log2(NUM_LINES)`, `TAG_W = 27 - IDX_W` (22 by default).
- One clock; reset is asynchronous and active-high.
- `clk_i  in  1`: clock; all state updates on the rising edge.
- `rst_i  in  1`: asynchronous, active-high reset.
- `cpu_req_i  in  1`: access request (MemRead | MemWrite of the MEM stage).
- `cpu_write_i  in  1`: 1 = store, 0 = load; valid with `cpu_req_i`.
- `cpu_addr_i  in  32`: byte address. Bits [4:2] select the word, [5+IDX_W-1:5] the index, [31:5+IDX_W] the tag. Bits [1:0] are ignored.
- `cpu_data_i  in  32`: store data.
- `cpu_data_o  out  32`: load data. Valid in the cycle `cpu_req_i & !cpu_write_i & !mem_stall_o`; 0 otherwise.
- `mem_stall_o  out  1`: pipeline stall, combinational.
- `mem_enable_o  out  1`: memory request, level.
- `mem_write_o  out  1`: 1 = block write-back, 0 = block fetch.
- `mem_addr_o  out  32`: block-aligned address; bits [4:0] are always 0.
- `mem_data_o  out  256`: write-back block. Word w sits at bits [32w+31:32w].
- `mem_data_i  in  256`: fetched block, same word layout.
- `mem_ack_i  in  1`: single-cycle completion pulse from memory.

## Operation
- Hit = `cpu_req_i & valid[idx] & (tag[idx] == addr tag)`.
- **States**: IDLE, WB, GAP, REFILL.
- **IDLE**
  - Load hit: `cpu_data_o` = the selected word, combinationally; stall is 0.
  - Store hit: at the clock edge, the selected word is overwritten and `dirty[idx]` is set to 1.
  - Miss (`cpu_req_i & !hit`): stall is 1 in the same cycle. `cpu_addr_i[31:5]` is latched as the miss block. The next state is WB if `valid & dirty`, else REFILL.
- **WB**
  - `mem_enable_o = 1`, `mem_write_o = 1`.
  - `mem_addr_o = {victim tag, idx, 5'b0}`; `mem_data_o` = victim line.
  - On `mem_ack_i`, go to GAP.
- **GAP**
  - `mem_enable_o = 0` for exactly one cycle, so the two transactions stay distinct.
  - Next state is REFILL.
- **REFILL**
  - `mem_enable_o = 1`, `mem_write_o = 0`; `mem_addr_o = {miss block, 5'b0}`.
  - On `mem_ack_i`: line is set to `mem_data_i`, tag set, `valid = 1`, `dirty = 0`; go to IDLE.
- Back in IDLE, the still-held request hits and completes normally. A store is merged at that point and sets dirty.
- `mem_stall_o = (state != IDLE) | (IDLE & cpu_req_i & !hit)`.
- The pipeline holds `cpu_*` stable while stall is 1. The controller uses only the latched miss block during WB, GAP and REFILL. If `cpu_req_i` drops mid-miss, the fill still completes and nothing is written.
- `mem_ack_i` is ignored when `mem_enable_o = 0`.
- In IDLE, `mem_addr_o` and `mem_data_o` are 0.

## Timing
- **Reset (async)**
  - State goes to IDLE; all valid and dirty bits are cleared.
  - `mem_enable_o = 0`, `mem_write_o = 0`, `mem_stall_o = 0` and `cpu_data_o = 0` while `rst_i` is high.
  - Tag and data contents need no reset.
  - Reset asserted mid-transaction drops `mem_enable_o` immediately. The partial line stays invalid and a pending write-back is lost.
- Hit latency is 0 extra cycles: stall is never asserted.
- **Clean miss**, request in cycle 0:
  - Stall is 1 in cycle 0; REFILL runs from cycle 1.
  - If ack arrives in cycle k, IDLE is entered in cycle k+1. The hit and stall = 0 occur in cycle k+1.
- **Dirty miss**:
  - WB from cycle 1, with ack in cycle a.
  - GAP in cycle a+1; REFILL from a+2, with ack in cycle r.
  - Stall is 0 in cycle r+1.
- Memory address, data and `mem_write_o` are stable for the whole time `mem_enable_o` is high.
- An ack in the first cycle of WB or REFILL is legal (minimum one cycle per transaction).

## Test plan
- **Reset, then load miss**: read 0x0000_0040; memory returns a block with word0 = 0x1111_1111 after a 10-cycle latency.
  - Stall is high for 11 cycles (cycle 0 through the ack cycle); no write-back occurs.
  - `cpu_data_o = 0x1111_1111` in the stall-low cycle.
- **Store hit**: write 0xDEAD_BEEF to 0x0000_0044 after the line above is filled.
  - No stall.
  - A following load of 0x44 returns 0xDEAD_BEEF with 0 stall cycles.
- **Dirty eviction**: load 0x0000_0440 (same index 2 as 0x40, tag differs).
  - WB to address 0x40 with word1 = 0xDEAD_BEEF.
  - One-cycle `mem_enable_o` gap.
  - REFILL from 0x440.
- **Store miss (write-allocate)**: store to a clean, invalid index.
  - REFILL only.
  - The line afterwards holds the store word merged into the fetched block, with dirty = 1.
- **Reset mid-REFILL**: assert `rst_i` 3 cycles into REFILL.
  - `mem_enable_o` and stall drop asynchronously.
  - A late `mem_ack_i` is ignored.
  - A reissued load misses again.
- **Request dropped mid-miss**: deassert `cpu_req_i` during REFILL.
  - The fill completes and the line becomes valid with dirty = 0.
  - Stall goes low after the ack.

Source files
------------

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate L1 data cache controller.
module dcache_ctrl #(
  parameter int NUM_LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         mem_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 27 - IDX_W;
  localparam logic [1:0] IDLE = 2'd0, WB = 2'd1, GAP = 2'd2, REFILL = 2'd3;
  logic [1:0]           state_q, state_d;
  logic [26:0]          miss_q, miss_d;
  logic [NUM_LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [255:0]         data_q [NUM_LINES];
  logic [IDX_W-1:0]     idx, midx;
  logic [TAG_W-1:0]     tag;
  logic [2:0]           word;
  logic                 idle, hit, miss, st_hit, fill, unused_lsb;
  assign idx        = cpu_addr_i[5+IDX_W-1:5];
  assign tag        = cpu_addr_i[31:5+IDX_W];
  assign word       = cpu_addr_i[4:2];
  assign unused_lsb = ^cpu_addr_i[1:0];
  assign midx       = miss_q[IDX_W-1:0];
  assign idle       = state_q == IDLE;
  assign hit        = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign miss       = cpu_req_i & ~hit;
  assign st_hit     = idle & hit & cpu_write_i;
  assign fill       = (state_q == REFILL) & mem_ack_i;
  // Outputs are forced quiet while reset is held, even though state already reads IDLE.
  assign mem_stall_o  = ~rst_i & (~idle | miss);
  assign cpu_data_o   = (cpu_req_i & ~cpu_write_i & ~mem_stall_o & ~rst_i) ? data_q[idx][{word, 5'b0} +: 32] : '0;
  assign mem_enable_o = ~rst_i & ((state_q == WB) | (state_q == REFILL));
  assign mem_write_o  = ~rst_i & (state_q == WB);
  assign mem_addr_o   = (state_q == WB) ? {tag_q[midx], midx, 5'b0} : (state_q == REFILL) ? {miss_q, 5'b0} : '0;
  assign mem_data_o   = (state_q == WB) ? data_q[midx] : '0;
  always_comb begin
    state_d = idle ? (miss ? ((valid_q[idx] & dirty_q[idx]) ? WB : REFILL) : IDLE)
            : (state_q == WB) ? (mem_ack_i ? GAP : WB)
            : (state_q == GAP) ? REFILL
            : (mem_ack_i ? IDLE : REFILL);
    miss_d  = (idle & miss) ? cpu_addr_i[31:5] : miss_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill) begin
      valid_d[midx] = 1'b1;
      dirty_d[midx] = 1'b0;
    end
    if (st_hit) dirty_d[idx] = 1'b1;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      miss_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      miss_q  <= miss_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end
  // Tag and data arrays carry no reset; valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[midx] <= mem_data_i;
      tag_q[midx]  <= miss_q[26:IDX_W];
    end else if (st_hit) begin
      data_q[idx][{word, 5'b0} +: 32] <= cpu_data_i;
    end
  end
endmodule
